// File: rtl/alu_pkg.sv
// Shared opcode encoding for the pipelined ALU (MIPS-style funct field).
package alu_pkg;

  localparam int unsigned NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus zero/carry/overflow/error flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic [NB_OP-1:0]   opcode,
  output logic [NB_DATA-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               ovf,
  output logic               err
);

  localparam int unsigned MSB = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

  logic [NB_DATA:0] sum;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    sum    = '0;
    case (opcode)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[NB_DATA-1:0];
        carry  = sum[NB_DATA];
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is the borrow (A < B).
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[NB_DATA-1:0];
        carry  = sum[NB_DATA];
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_SRA: begin
        if (b >= SHIFT_LIM) result = {NB_DATA{a[MSB]}};
        else                result = $unsigned($signed(a) >>> b);
      end
      OP_SRL: begin
        if (b >= SHIFT_LIM) result = '0;
        else                result = a >> b;
      end
      default: err = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline (operand register, result register) with valid/ready
// handshakes on both sides and full backpressure.
module alu_pipe #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_dato_a,
  input  logic [NB_DATA-1:0] i_dato_b,
  input  logic [NB_OP-1:0]   i_opcode,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_err
);

  logic               s1_valid;
  logic [NB_DATA-1:0] s1_a;
  logic [NB_DATA-1:0] s1_b;
  logic [NB_OP-1:0]   s1_op;

  logic               s2_adv;
  logic               accept;
  logic               xfer;

  logic [NB_DATA-1:0] core_result;
  logic               core_zero;
  logic               core_carry;
  logic               core_ovf;
  logic               core_err;

  always_comb begin
    s2_adv  = !o_valid || i_ready;
    o_ready = !s1_valid || s2_adv;
    accept  = i_valid && o_ready;
    xfer    = s1_valid && s2_adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= i_dato_a;
      s1_b     <= i_dato_b;
      s1_op    <= i_opcode;
    end else if (xfer) begin
      s1_valid <= 1'b0;
    end
  end

  alu_core #(
    .NB_DATA(NB_DATA)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .opcode (s1_op),
    .result (core_result),
    .zero   (core_zero),
    .carry  (core_carry),
    .ovf    (core_ovf),
    .err    (core_err)
  );

  // Result register only loads on a transfer, so it holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b0;
      o_carry  <= 1'b0;
      o_ovf    <= 1'b0;
      o_err    <= 1'b0;
    end else if (xfer) begin
      o_valid  <= 1'b1;
      o_result <= core_result;
      o_zero   <= core_zero;
      o_carry  <= core_carry;
      o_ovf    <= core_ovf;
      o_err    <= core_err;
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors, backpressure, random streaming and
// mid-flight reset, all scored against an arithmetic reference model.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       ovf;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_dato_a = '0;
  logic [7:0] i_dato_b = '0;
  logic [5:0] i_opcode = '0;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_result;
  logic       o_zero;
  logic       o_carry;
  logic       o_ovf;
  logic       o_err;

  int vectors = 0;
  int miscompares = 0;
  int acc_count = 0;
  logic last_acc = 1'b0;
  logic held_v = 1'b0;
  logic [31:0] held = '0;
  res_t q[$];

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  alu_pipe #(
    .NB_DATA(8),
    .NB_OP  (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_dato_a (i_dato_a),
    .i_dato_b (i_dato_b),
    .i_opcode (i_opcode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_zero   (o_zero),
    .o_carry  (o_carry),
    .o_ovf    (o_ovf),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r = 0;
    res_t m = '0;
    case (op)
      6'h20: begin
        r = ua + ub;
        m.carry = (r > 255);
        m.ovf = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      6'h22: begin
        r = ua - ub;
        m.carry = (ua < ub);
        m.ovf = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      6'h24: r = ua & ub;
      6'h25: r = ua | ub;
      6'h26: r = ua ^ ub;
      6'h27: r = ~(ua | ub);
      6'h03: r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      6'h02: r = (ub >= 8) ? 0 : (ua >> ub);
      default: m.err = 1'b1;
    endcase
    m.result = r[7:0];
    m.zero = (m.result == 8'h00);
    return m;
  endfunction

  function automatic logic [31:0] outw();
    return 32'({o_result, o_zero, o_carry, o_ovf, o_err});
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes just before the edge, then step past it.
  task automatic cycle();
    res_t e;
    #1;
    if (held_v) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_stable", outw(), held);
    end
    last_acc = i_valid && o_ready;
    if (o_valid && i_ready) begin
      if (q.size() == 0) chk("spurious_out", 32'(o_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("result", outw(), 32'(e));
      end
    end
    if (last_acc) begin
      q.push_back(model(i_dato_a, i_dato_b, i_opcode));
      acc_count++;
    end
    held_v = o_valid && !i_ready;
    held = outw();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    int n = 0;
    i_valid = 1'b1;
    i_dato_a = a;
    i_dato_b = b;
    i_opcode = op;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      cycle();
      n++;
    end
    if (!last_acc) chk("send_timeout", 32'(last_acc), 32'd1);
    i_valid = 1'b0;
    i_dato_a = 8'h5A;
    i_dato_b = 8'hA5;
    i_opcode = 6'h3F;
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (q.size() != 0 && n < 30) begin
      cycle();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    cycle();
    cycle();
  endtask

  task automatic directed(string tag, logic [7:0] a, logic [7:0] b, logic [5:0] op, res_t k);
    i_ready = 1'b1;
    send(a, b, op);
    chk({tag, "_lat1"}, 32'(o_valid), 32'd0);
    cycle();
    chk({tag, "_lat2"}, 32'(o_valid), 32'd1);
    chk(tag, outw(), 32'(k));
    drain();
  endtask

  initial begin
    int n;
    int guard;
    int acc0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_out", outw(), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(o_ready), 32'd1);

    directed("add",     8'h02, 8'h08, 6'h20, '{8'h0A, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("sub",     8'h02, 8'h08, 6'h22, '{8'hFA, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("add_ovf", 8'h7F, 8'h01, 6'h20, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0});
    directed("add_cy",  8'hFF, 8'h01, 6'h20, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    directed("sra_big", 8'h80, 8'h09, 6'h03, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("srl",     8'h80, 8'h03, 6'h02, '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("bad_op",  8'h12, 8'h34, 6'h3F, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1});

    // Backpressure: two tuples fill the pipe, the third waits at the source.
    i_ready = 1'b0;
    acc0 = acc_count;
    send(8'h33, 8'h44, 6'h20);
    send(8'hF0, 8'h3C, 6'h24);
    i_valid = 1'b1;
    i_dato_a = 8'h81;
    i_dato_b = 8'h18;
    i_opcode = 6'h25;
    #1;
    chk("bp_ready_low", 32'(o_ready), 32'd0);
    cycle();
    cycle();
    cycle();
    chk("bp_accepts", 32'(acc_count - acc0), 32'd2);
    i_ready = 1'b1;
    send(8'h81, 8'h18, 6'h25);
    drain();
    chk("bp_total", 32'(acc_count - acc0), 32'd3);

    // Random streaming with a randomly stalling sink.
    n = 0;
    guard = 0;
    i_valid = 1'b1;
    i_dato_a = 8'($urandom);
    i_dato_b = 8'($urandom);
    i_opcode = ops[$urandom_range(0, 7)];
    while (n < 16 && guard < 300) begin
      i_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc) begin
        n++;
        i_dato_a = 8'($urandom);
        i_dato_b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
        i_opcode = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      end
      guard++;
    end
    chk("stream_count", 32'(n), 32'd16);
    drain();

    // Reset with two tuples in flight.
    i_ready = 1'b0;
    send(8'h10, 8'h20, 6'h20);
    send(8'h0F, 8'hF0, 6'h26);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_out", outw(), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    q.delete();
    held_v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("no_stale", 32'(o_valid), 32'd0);
      cycle();
    end
    chk("post_rst_ready2", 32'(o_ready), 32'd1);
    directed("after_rst", 8'h55, 8'h0F, 6'h27, '{8'hA0, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
